// File: rtl/det_divider.sv
// det_divider: signed fixed-point divider, one restoring radix-2 step per cycle.
//   Computes trunc_toward_zero((dividend << FRAC_BITS) / divisor) on unsigned
//   DOUT_W-bit magnitudes, then applies the XOR of the operand signs.
//   Each operand channel is buffered by a single-entry register.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   s_axis_dividend_t*         dividend stream; tready = buffer empty (advisory)
//   s_axis_divisor_t*          divisor stream;  tready = buffer empty (advisory)
//   m_axis_dout_tdata          signed quotient, FRAC_BITS fractional bits
//   m_axis_dout_tvalid         one-cycle result strobe, no backpressure
//   m_axis_dout_tuser          divide-by-zero flag, qualified by tvalid
//   overflow                   sticky: an operand was dropped on a full buffer
//
// DOUT_W must equal DIVIDEND_W + FRAC_BITS and be at least DIVISOR_W.
module det_divider #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 32,
  parameter int DOUT_W     = 48,
  parameter int FRAC_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIVIDEND_W-1:0] s_axis_dividend_tdata,
  input  logic                  s_axis_dividend_tvalid,
  output logic                  s_axis_dividend_tready,
  input  logic [DIVISOR_W-1:0]  s_axis_divisor_tdata,
  input  logic                  s_axis_divisor_tvalid,
  output logic                  s_axis_divisor_tready,
  output logic [DOUT_W-1:0]     m_axis_dout_tdata,
  output logic                  m_axis_dout_tvalid,
  output logic                  m_axis_dout_tuser,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(DOUT_W);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_SIGN} state_t;

  state_t                  state;
  logic [DIVIDEND_W-1:0]   dvd_buf;
  logic                    dvd_full;
  logic [DIVISOR_W-1:0]    dvs_buf;
  logic                    dvs_full;

  logic [DOUT_W-1:0]       quo;      // numerator shifts out the top, quotient bits shift in
  logic [DIVISOR_W-1:0]    rem;      // remainder < |divisor| <= 2^(DIVISOR_W-1)
  logic [DOUT_W-1:0]       dvs_mag_r;
  logic                    res_neg;
  logic                    dvd_neg_r;
  logic                    div_zero;
  logic [CNT_W-1:0]        cnt;

  logic                    load;
  logic                    dvd_drop, dvs_drop;
  logic                    dvd_neg, dvs_neg;
  logic [DIVIDEND_W-1:0]   dvd_mag;
  logic [DIVISOR_W-1:0]    dvs_mag;
  logic [DIVISOR_W:0]      rem_sh;
  logic                    rem_ge;

  assign load = (state == S_IDLE) && dvd_full && dvs_full;

  // A sample landing on the load edge refills the buffer being emptied,
  // so only a full buffer that is not being loaded drops.
  assign dvd_drop = s_axis_dividend_tvalid && dvd_full && !load;
  assign dvs_drop = s_axis_divisor_tvalid  && dvs_full && !load;

  assign s_axis_dividend_tready = !dvd_full;
  assign s_axis_divisor_tready  = !dvs_full;

  // Unsigned magnitudes: -2^(W-1) maps to 2^(W-1), which still fits W bits.
  assign dvd_neg = dvd_buf[DIVIDEND_W-1];
  assign dvs_neg = dvs_buf[DIVISOR_W-1];
  assign dvd_mag = dvd_neg ? (~dvd_buf + 1'b1) : dvd_buf;
  assign dvs_mag = dvs_neg ? (~dvs_buf + 1'b1) : dvs_buf;

  assign rem_sh = {rem, quo[DOUT_W-1]};
  assign rem_ge = ({{(DOUT_W-DIVISOR_W){1'b0}}, rem_sh} >= {1'b0, dvs_mag_r});

  // Operand buffers and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_buf  <= '0;
      dvd_full <= 1'b0;
      dvs_buf  <= '0;
      dvs_full <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (s_axis_dividend_tvalid && !dvd_drop) begin
        dvd_buf  <= s_axis_dividend_tdata;
        dvd_full <= 1'b1;
      end else if (load) begin
        dvd_full <= 1'b0;
      end
      if (s_axis_divisor_tvalid && !dvs_drop) begin
        dvs_buf  <= s_axis_divisor_tdata;
        dvs_full <= 1'b1;
      end else if (load) begin
        dvs_full <= 1'b0;
      end
      if (dvd_drop || dvs_drop) overflow <= 1'b1;
    end
  end

  // Division engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      quo                <= '0;
      rem                <= '0;
      dvs_mag_r          <= '0;
      res_neg            <= 1'b0;
      dvd_neg_r          <= 1'b0;
      div_zero           <= 1'b0;
      cnt                <= '0;
      m_axis_dout_tdata  <= '0;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tuser  <= 1'b0;
    end else begin
      m_axis_dout_tvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load) begin
            quo       <= {dvd_mag, {FRAC_BITS{1'b0}}};
            rem       <= '0;
            dvs_mag_r <= DOUT_W'(dvs_mag);
            res_neg   <= dvd_neg ^ dvs_neg;
            dvd_neg_r <= dvd_neg;
            div_zero  <= (dvs_buf == '0);
            cnt       <= '0;
            state     <= S_ITER;
          end
        end
        S_ITER: begin
          rem <= rem_ge ? DIVISOR_W'(rem_sh - {1'b0, dvs_mag_r[DIVISOR_W-1:0]})
                        : rem_sh[DIVISOR_W-1:0];
          quo <= {quo[DOUT_W-2:0], rem_ge};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DOUT_W-1)) state <= S_SIGN;
        end
        S_SIGN: begin
          // Divide-by-zero saturates toward the dividend's sign
          if (div_zero)
            m_axis_dout_tdata <= dvd_neg_r ? {1'b1, {(DOUT_W-1){1'b0}}}
                                           : {1'b0, {(DOUT_W-1){1'b1}}};
          else
            m_axis_dout_tdata <= res_neg ? (~quo + 1'b1) : quo;
          m_axis_dout_tuser  <= div_zero;
          m_axis_dout_tvalid <= 1'b1;
          state              <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
